// File: rtl/matrix_result_reader_pkg.sv
// ---------------------------------------------------------------------------
// matrix_pkg
//   Shared constants and types for the matrix result reader slice.
//   DATA_W : element width (Q-format, passed through untouched)
//   DIM    : matrix dimension (power of 2)
//   ADDR_W : BRAM address width, log2(DIM*DIM)
//   Types  : elem_t, addr_t, mrr_tag_t {row,col,last}, mrr_entry_t {data,tag},
//            mrr_state_e {IDLE, FETCH, DRAIN, DONE}
//   idx_to_tag() turns a row-major element index into its row/col/last tag.
// ---------------------------------------------------------------------------
package matrix_pkg;

    localparam int DATA_W = 16;
    localparam int DIM    = 4;
    localparam int ADDR_W = 4;
    localparam int IDX_W  = $clog2(DIM);
    localparam int N_ELEM = DIM * DIM;

    typedef logic [DATA_W-1:0] elem_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam addr_t LAST_IDX = addr_t'(N_ELEM - 1);

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
        logic             last;
    } mrr_tag_t;

    typedef struct packed {
        elem_t    data;
        mrr_tag_t tag;
    } mrr_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } mrr_state_e;

    // DIM is a power of 2, so row/col are plain bit fields of the index.
    function automatic mrr_tag_t idx_to_tag(input addr_t idx);
        mrr_tag_t t;
        t.row  = IDX_W'(idx >> IDX_W);
        t.col  = IDX_W'(idx & addr_t'(DIM - 1));
        t.last = (idx == LAST_IDX);
        return t;
    endfunction

endpackage

// File: rtl/matrix_result_reader_if.sv
// ---------------------------------------------------------------------------
// matrix_result_reader_if
//   Bundles the BRAM read port and the outgoing element stream.
//   ram_en/ram_addr/ram_dout : single-port BRAM read, data 1 cycle after ram_en
//   m_valid/m_ready          : stream handshake
//   m_data/m_row/m_col/m_last: element payload and tags
//   modport master : the reader (drives BRAM request and stream)
//   modport slave  : the environment (BRAM model + stream sink)
// ---------------------------------------------------------------------------
interface matrix_result_reader_if;
    import matrix_pkg::*;

    logic             ram_en;
    addr_t            ram_addr;
    elem_t            ram_dout;

    logic             m_valid;
    logic             m_ready;
    elem_t            m_data;
    logic [IDX_W-1:0] m_row;
    logic [IDX_W-1:0] m_col;
    logic             m_last;

    modport master (
        output ram_en, ram_addr,
        input  ram_dout,
        output m_valid, m_data, m_row, m_col, m_last,
        input  m_ready
    );

    modport slave (
        input  ram_en, ram_addr,
        output ram_dout,
        input  m_valid, m_data, m_row, m_col, m_last,
        output m_ready
    );

endinterface

// File: rtl/matrix_result_reader_fifo.sv
// ---------------------------------------------------------------------------
// mrr_skid_fifo
//   Two-entry register FIFO carrying {data, row, col, last}. The head entry
//   is a register, so the stream payload comes straight from flops and stays
//   put while the sink stalls.
//   clk, reset_n : clock / asynchronous active-low reset
//   push, push_entry : write side (never pushed when full; the reader's
//                      credit check guarantees that)
//   pop          : head consumed this cycle (only asserted when count != 0)
//   head_entry   : current head (valid when count != 0)
//   count        : occupancy 0..2
// ---------------------------------------------------------------------------
module mrr_skid_fifo
    import matrix_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  mrr_entry_t push_entry,
    input  logic       pop,
    output mrr_entry_t head_entry,
    output logic [1:0] count
);

    mrr_entry_t head_reg;
    mrr_entry_t tail_reg;
    logic [1:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            case (count_reg)
                2'd0: begin
                    if (push) head_reg <= push_entry;
                end
                2'd1: begin
                    // With a simultaneous pop the new entry goes straight to the head.
                    if (push && pop)  head_reg <= push_entry;
                    else if (push)    tail_reg <= push_entry;
                end
                default: begin
                    if (pop) begin
                        head_reg <= tail_reg;
                        if (push) tail_reg <= push_entry;
                    end
                end
            endcase
            count_reg <= count_reg + 2'(push) - 2'(pop);
        end
    end

    assign head_entry = head_reg;
    assign count      = count_reg;

endmodule

// File: rtl/matrix_result_reader.sv
// ---------------------------------------------------------------------------
// matrix_result_reader
//   Drains the DIM x DIM result matrix from the result BRAM in row-major
//   order and streams each element out with its row/col tags and a last flag.
//   Ports:
//     clk      : clock, rising edge
//     reset_n  : asynchronous active-low reset
//     start    : pulse to begin a drain (ignored unless idle)
//     busy     : high from the cycle after start acceptance until done
//     done     : one-cycle pulse the cycle after the last element transfer
//     bus      : matrix_result_reader_if.master (BRAM read port + stream)
//     checksum : running modulo-2^DATA_W sum of transferred elements,
//                present only when MRR_CHECKSUM_EN is defined
//   Optional feature macro: MRR_CHECKSUM_EN
// ---------------------------------------------------------------------------
module matrix_result_reader
    import matrix_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    matrix_result_reader_if.master bus
`ifdef MRR_CHECKSUM_EN
    ,
    output elem_t                  checksum
`endif
);

    mrr_state_e state_reg, state_next;
    addr_t      rd_idx_reg, rd_idx_next;
    logic       inflight_reg;
    addr_t      inflight_idx_reg;

    mrr_entry_t push_entry;
    mrr_entry_t head_entry;
    logic [1:0] fifo_count;
    logic       m_valid_int;
    logic       pop;
    logic [1:0] credit;
    logic       issue;

    assign m_valid_int = (fifo_count != 2'd0);
    assign pop         = m_valid_int && bus.m_ready;

    // Entries already owned by the FIFO plus the read still in flight, minus
    // the one leaving this cycle. Issuing only below 2 keeps the FIFO from
    // ever overflowing while the sink stalls.
    assign credit = fifo_count + 2'(inflight_reg) - 2'(pop);
    assign issue  = (state_reg == FETCH) && (credit < 2'd2);

    always_comb begin
        state_next  = state_reg;
        rd_idx_next = rd_idx_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = FETCH;
                    rd_idx_next = '0;
                end
            end
            FETCH: begin
                if (issue) begin
                    // The index stops at the last element rather than wrapping.
                    if (rd_idx_reg == LAST_IDX) state_next  = DRAIN;
                    else                        rd_idx_next = rd_idx_reg + addr_t'(1);
                end
            end
            DRAIN: begin
                // The last-tagged element is the final one, so its transfer
                // leaves both the FIFO and the read pipeline empty.
                if (pop && head_entry.tag.last) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            rd_idx_reg       <= '0;
            inflight_reg     <= 1'b0;
            inflight_idx_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rd_idx_reg   <= rd_idx_next;
            inflight_reg <= issue;
            if (issue) inflight_idx_reg <= rd_idx_reg;
        end
    end

    // BRAM data is valid the cycle after ram_en; tag it with the index it was read from.
    assign push_entry.data = bus.ram_dout;
    assign push_entry.tag  = idx_to_tag(inflight_idx_reg);

    mrr_skid_fifo u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (inflight_reg),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (fifo_count)
    );

    assign bus.ram_en   = issue;
    assign bus.ram_addr = rd_idx_reg;
    assign bus.m_valid  = m_valid_int;
    assign bus.m_data   = head_entry.data;
    assign bus.m_row    = head_entry.tag.row;
    assign bus.m_col    = head_entry.tag.col;
    assign bus.m_last   = head_entry.tag.last;

    assign busy = (state_reg == FETCH) || (state_reg == DRAIN);
    assign done = (state_reg == DONE);

`ifdef MRR_CHECKSUM_EN
    elem_t checksum_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            checksum_reg <= '0;
        end else if ((state_reg == IDLE) && start) begin
            checksum_reg <= '0;
        end else if (pop) begin
            checksum_reg <= checksum_reg + head_entry.data;
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// ---------------------------------------------------------------------------
// tb_matrix_result_reader
//   Scoreboard bench: each start pushes the 16 expected elements (data from
//   the bench's BRAM image, row/col/last from plain index arithmetic) into a
//   queue; an independent monitor pops and compares on every transfer.
// ---------------------------------------------------------------------------
module tb_matrix_result_reader;
    import matrix_pkg::*;

    typedef struct {
        elem_t data;
        int    row;
        int    col;
        bit    last;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic start   = 1'b0;
    logic busy;
    logic done;
`ifdef MRR_CHECKSUM_EN
    elem_t checksum;
`endif

    matrix_result_reader_if bus();

    matrix_result_reader dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
`ifdef MRR_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    // BRAM image and one-cycle read model
    elem_t mem [N_ELEM];
    always @(posedge clk) begin
        if (bus.ram_en) bus.ram_dout <= mem[bus.ram_addr];
    end

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    exp_t  exp_q[$];
    elem_t exp_sum;
    int    run_xfer    = 0;
    int    run_issue   = 0;
    int    done_cnt    = 0;
    int    start_cyc   = 0;
    int    last_xfer_cyc = 0;
    bit    timing_chk  = 1'b0;
    int    ready_mode  = 3;   // 0 always, 1 pattern 1,0,0,1, 2 random, 3 held low
    int    ready_phase = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Sink ready generator
    initial begin
        bus.m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.m_ready = 1'b1;
                1:       bus.m_ready = ((ready_phase % 4) == 0) || ((ready_phase % 4) == 3);
                2:       bus.m_ready = 1'($urandom_range(0, 1));
                default: bus.m_ready = 1'b0;
            endcase
            ready_phase++;
        end
    end

    // Monitor / scoreboard
    initial begin
        exp_t e;
        int   outst;
        bit   p;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                p     = bus.m_valid && bus.m_ready;
                outst = run_issue + int'(bus.ram_en) - run_xfer - int'(p);
                if (bus.ram_en) begin
                    check("outstanding_le2", 32'(outst <= 2), 32'd1);
                    check("issue_within_matrix", 32'(run_issue < N_ELEM), 32'd1);
                    run_issue++;
                end
                if (p) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL xfer_unexpected: got data 0x%0h, expected no transfer (cycle %0d)",
                                 bus.m_data, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("xfer_data", 32'(bus.m_data), 32'(e.data));
                        check("xfer_row",  32'(bus.m_row),  32'(e.row));
                        check("xfer_col",  32'(bus.m_col),  32'(e.col));
                        check("xfer_last", 32'(bus.m_last), 32'(e.last));
                        $display("xfer %0d: data=0x%0h row=%0d col=%0d last=%0d",
                                 run_xfer, bus.m_data, bus.m_row, bus.m_col, bus.m_last);
                    end
                    if (timing_chk) begin
                        if (run_xfer == 0) check("first_xfer_cycle", 32'(cyc), 32'(start_cyc + 3));
                        else               check("xfer_back_to_back", 32'(cyc), 32'(last_xfer_cyc + 1));
                    end
                    run_xfer++;
                    last_xfer_cyc = cyc;
                end
                if (done) begin
                    check("done_after_last", 32'(cyc), 32'(last_xfer_cyc + 1));
                    check("done_queue_empty", 32'(exp_q.size()), 32'd0);
                    check("done_busy_low", 32'(busy), 32'd0);
`ifdef MRR_CHECKSUM_EN
                    check("checksum_at_done", 32'(checksum), 32'(exp_sum));
`endif
                    done_cnt++;
                end
            end
        end
    end

    task automatic start_run();
        exp_t e;
        exp_q.delete();
        exp_sum = '0;
        for (int k = 0; k < N_ELEM; k++) begin
            e.data = mem[k];
            e.row  = k / DIM;
            e.col  = k % DIM;
            e.last = (k == N_ELEM - 1);
            exp_q.push_back(e);
            exp_sum = exp_sum + mem[k];
        end
        run_xfer  = 0;
        run_issue = 0;
        done_cnt  = 0;
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done_cnt == 0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check({name, "_one_done"},   32'(done_cnt), 32'd1);
        check({name, "_xfer_count"}, 32'(run_xfer), 32'(N_ELEM));
        check({name, "_idle_busy"},  32'(busy), 32'd0);
        check({name, "_idle_valid"}, 32'(bus.m_valid), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_busy"},    32'(busy), 32'd0);
        check({name, "_done"},    32'(done), 32'd0);
        check({name, "_ram_en"},  32'(bus.ram_en), 32'd0);
        check({name, "_m_valid"}, 32'(bus.m_valid), 32'd0);
        check({name, "_m_data"},  32'(bus.m_data), 32'd0);
        check({name, "_m_row"},   32'(bus.m_row), 32'd0);
        check({name, "_m_col"},   32'(bus.m_col), 32'd0);
        check({name, "_m_last"},  32'(bus.m_last), 32'd0);
`ifdef MRR_CHECKSUM_EN
        check({name, "_checksum"}, 32'(checksum), 32'd0);
`endif
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < N_ELEM; k++) mem[k] = elem_t'(16'h0100 * k);
    endtask

    task automatic fill_random();
        for (int k = 0; k < N_ELEM; k++) mem[k] = elem_t'($urandom);
    endtask

    initial begin
        #1 bus.ram_dout = '0;
    end

    initial begin
        // Reset state
        #2;
        check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("post_reset_idle");

        // T1: ramp data, sink always ready, cycle-exact timing
        fill_ramp();
        ready_mode = 0;
        timing_chk = 1'b1;
        @(posedge clk);
        start_run();
        wait_done("t1");

        // T2: ready pattern 1,0,0,1
        ready_mode  = 1;
        ready_phase = 0;
        timing_chk  = 1'b0;
        @(posedge clk);
        start_run();
        wait_done("t2");

        // T3: sink stalled for 20 cycles after start
        ready_mode = 3;
        @(posedge clk);
        @(posedge clk);
        start_run();
        repeat (19) @(posedge clk);
        #2;
        check("t3_ram_en_pulses", 32'(run_issue), 32'd2);
        check("t3_valid_held",    32'(bus.m_valid), 32'd1);
        check("t3_data_held",     32'(bus.m_data), 32'h0000);
        check("t3_row_held",      32'(bus.m_row), 32'd0);
        check("t3_col_held",      32'(bus.m_col), 32'd0);
        ready_mode = 0;
        wait_done("t3");

        // T4: second start during the drain is ignored
        fill_random();
        ready_mode = 0;
        timing_chk = 1'b1;
        @(posedge clk);
        start_run();
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("t4");

        // T5: reset after 7 transfers aborts; fresh start replays from element 0
        fill_random();
        start_run();
        begin
            int n;
            n = 0;
            while (run_xfer < 7 && n < 100) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        check("t5_reached_7", 32'(run_xfer), 32'd7);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t5_abort");
        repeat (3) @(posedge clk);
        #1;
        check("t5_no_done", 32'(done_cnt), 32'd0);
        reset_n = 1'b1;
        start_run();
        wait_done("t5_replay");

`ifdef MRR_CHECKSUM_EN
        // T6: checksum wrap and small sum
        timing_chk = 1'b0;
        for (int k = 0; k < N_ELEM; k++) mem[k] = 16'hF000;
        start_run();
        wait_done("t6a");
        check("t6a_checksum", 32'(checksum), 32'h0000);
        for (int k = 0; k < N_ELEM; k++) mem[k] = elem_t'(k + 1);
        start_run();
        wait_done("t6b");
        check("t6b_checksum", 32'(checksum), 32'h0088);
        repeat (3) @(posedge clk);
        #1;
        check("t6b_checksum_stable", 32'(checksum), 32'h0088);
`endif

        // Random data with random sink back-pressure
        timing_chk = 1'b0;
        ready_mode = 2;
        for (int r = 0; r < 4; r++) begin
            fill_random();
            start_run();
            wait_done("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
